// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SpartanMC SPI slave: register offsets, bit positions
// and FSM state encoding.
package spi_slave_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_RX_OVERFLOW  = 4;
    localparam int ST_TX_UNDERRUN  = 5;
    localparam int ST_FRAME_ABORT  = 6;
    localparam int ST_CS_ACTIVE    = 7;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_RX_IE  = 1;
    localparam int CTRL_TX_IE  = 2;
    localparam int CTRL_FLUSH  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_slave_fifo.sv
// 8-bit synchronous FIFO with push/pop/flush; head is visible combinationally so a
// bus read can return it in the same access cycle that pops it.
module spi_slave_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/spmc_spi_slave.sv
// SPI mode-0 slave peripheral for the SpartanMC bus: oversampled SPI pins,
// byte framing FSM, RX/TX FIFOs and a DATA/STATUS/CTRL register file.
module spmc_spi_slave
    import spi_slave_pkg::*;
#(
    parameter logic [9:0] BASE_ADR   = 10'h0,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
    input  logic        clk_peri,
    input  logic        reset,
    input  logic [17:0] do_peri,
    output logic [17:0] di_peri,
    input  logic [9:0]  addr_peri,
    input  logic        access_peri,
    input  logic        wr_peri,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq
);
    logic sck_meta_reg, sck_sync_reg, sck_prev_reg;
    logic cs_meta_reg, cs_sync_reg, cs_prev_reg;
    logic mosi_meta_reg, mosi_sync_reg;

    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            sck_meta_reg  <= 1'b0;
            sck_sync_reg  <= 1'b0;
            sck_prev_reg  <= 1'b0;
            cs_meta_reg   <= 1'b1;
            cs_sync_reg   <= 1'b1;
            cs_prev_reg   <= 1'b1;
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
        end else begin
            sck_meta_reg  <= spi_sck;
            sck_sync_reg  <= sck_meta_reg;
            sck_prev_reg  <= sck_sync_reg;
            cs_meta_reg   <= spi_cs_n;
            cs_sync_reg   <= cs_meta_reg;
            cs_prev_reg   <= cs_sync_reg;
            mosi_meta_reg <= spi_mosi;
            mosi_sync_reg <= mosi_meta_reg;
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise;
    assign sck_rise = sck_sync_reg & ~sck_prev_reg;
    assign sck_fall = ~sck_sync_reg & sck_prev_reg;
    assign cs_fall  = ~cs_sync_reg & cs_prev_reg;
    assign cs_rise  = cs_sync_reg & ~cs_prev_reg;

    // Bus decode
    logic       sel, bus_wr, bus_rd;
    logic [1:0] reg_adr;
    logic       unused_bits;
    assign sel         = access_peri & (addr_peri[9:6] == BASE_ADR[9:6]);
    assign bus_wr      = sel & wr_peri;
    assign bus_rd      = sel & ~wr_peri;
    assign reg_adr     = addr_peri[1:0];
    assign unused_bits = ^{do_peri[17:8], addr_peri[5:2]};

    logic [2:0] ctrl_reg;
    logic       ovf_reg, und_reg, abort_reg;
    logic       enable;
    assign enable = ctrl_reg[CTRL_ENABLE];

    logic       flush, tx_push, rx_pop, rx_push, tx_pop;
    logic [7:0] rx_head, tx_head, rx_byte;
    logic       rx_full, rx_empty, tx_full, tx_empty;

    assign flush   = bus_wr & (reg_adr == REG_CTRL) & do_peri[CTRL_FLUSH];
    assign tx_push = bus_wr & (reg_adr == REG_DATA);
    assign rx_pop  = bus_rd & (reg_adr == REG_DATA);

    spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk_peri),
        .rst_n (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush),
        .din   (rx_byte),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk_peri),
        .rst_n (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush),
        .din   (do_peri[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Framing FSM
    spi_state_t state_reg, state_next;
    logic [2:0] bit_cnt_reg;
    logic       byte_done_reg;
    logic [7:0] tx_shift_reg, rx_shift_reg;
    logic       load_req, shift_req, capture, abort_set;

    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_req   = 1'b0;
        shift_req  = 1'b0;
        capture    = 1'b0;
        abort_set  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cs_fall && enable) state_next = S_LOAD;
            end
            S_LOAD: begin
                load_req   = 1'b1;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (cs_rise) begin
                    state_next = S_IDLE;
                    abort_set  = (bit_cnt_reg != 3'd0);
                end else begin
                    capture = sck_rise;
                    if (sck_fall) begin
                        load_req  = byte_done_reg;
                        shift_req = ~byte_done_reg;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign tx_pop  = load_req;
    assign rx_byte = {rx_shift_reg[6:0], mosi_sync_reg};
    assign rx_push = capture & (bit_cnt_reg == 3'd7);

    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            tx_shift_reg  <= 8'hFF;
            rx_shift_reg  <= 8'h00;
            bit_cnt_reg   <= 3'd0;
            byte_done_reg <= 1'b0;
        end else begin
            if (load_req)       tx_shift_reg <= tx_empty ? IDLE_BYTE : tx_head;
            else if (shift_req) tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
            if (state_reg == S_LOAD) begin
                bit_cnt_reg <= 3'd0;
            end else if (capture) begin
                rx_shift_reg <= rx_byte;
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            end
            if (load_req)     byte_done_reg <= 1'b0;
            else if (rx_push) byte_done_reg <= 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    logic status_wr;
    assign status_wr = bus_wr & (reg_adr == REG_STATUS);

    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            ctrl_reg  <= 3'd0;
            ovf_reg   <= 1'b0;
            und_reg   <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            if (bus_wr && reg_adr == REG_CTRL) ctrl_reg <= do_peri[2:0];
            ovf_reg   <= (ovf_reg & ~(status_wr & do_peri[ST_RX_OVERFLOW]))
                       | (rx_push & rx_full & ~rx_pop);
            und_reg   <= (und_reg & ~(status_wr & do_peri[ST_TX_UNDERRUN]))
                       | (load_req & tx_empty);
            abort_reg <= (abort_reg & ~(status_wr & do_peri[ST_FRAME_ABORT]))
                       | abort_set;
        end
    end

    logic [7:0] status, rd_data;
    assign status = {~cs_sync_reg, abort_reg, und_reg, ovf_reg,
                     tx_full, tx_empty, rx_full, ~rx_empty};

    always_comb begin
        rd_data = 8'h00;
        case (reg_adr)
            REG_DATA:   rd_data = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: rd_data = status;
            REG_CTRL:   rd_data = {5'd0, ctrl_reg};
            default:    rd_data = 8'h00;
        endcase
    end

    assign di_peri     = bus_rd ? {10'd0, rd_data} : 18'd0;
    assign spi_miso    = tx_shift_reg[7];
    assign spi_miso_oe = (state_reg != S_IDLE);
    assign irq = (ctrl_reg[CTRL_RX_IE] & ~rx_empty)
               | (ctrl_reg[CTRL_TX_IE] & ~tx_full)
               | (ctrl_reg[CTRL_RX_IE] & (ovf_reg | und_reg | abort_reg));

endmodule

// File: tb/tb_spmc_spi_slave.sv
// Bench for spmc_spi_slave: register table, directed frames and randomized frames
// checked against a queue-based model of the peripheral.
module tb_spmc_spi_slave;

    logic        clk_peri = 1'b0;
    logic        reset = 1'b0;
    logic [17:0] do_peri = '0;
    logic [17:0] di_peri;
    logic [9:0]  addr_peri = '0;
    logic        access_peri = 1'b0;
    logic        wr_peri = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_out [8];
    logic [7:0] m_in  [8];

    always #5 clk_peri = ~clk_peri;

    spmc_spi_slave #(.BASE_ADR(10'h0), .FIFO_DEPTH(4), .IDLE_BYTE(8'hFF)) dut (
        .clk_peri    (clk_peri),
        .reset       (reset),
        .do_peri     (do_peri),
        .di_peri     (di_peri),
        .addr_peri   (addr_peri),
        .access_peri (access_peri),
        .wr_peri     (wr_peri),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .irq         (irq)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk_peri);
        access_peri = 1'b1; wr_peri = 1'b1; addr_peri = a; do_peri = {10'd0, d};
        @(negedge clk_peri);
        access_peri = 1'b0; wr_peri = 1'b0;
        $display("bus wr  adr=%03h data=%02h", a, d);
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [7:0] d);
        @(negedge clk_peri);
        access_peri = 1'b1; wr_peri = 1'b0; addr_peri = a;
        #1;
        d = di_peri[7:0];
        check("di_peri_upper", int'(di_peri[17:8]), 0);
        @(negedge clk_peri);
        access_peri = 1'b0;
        $display("bus rd  adr=%03h data=%02h", a, d);
    endtask

    task automatic read_check(input string name, input logic [9:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, int'(d), int'(exp));
    endtask

    // SPI master, mode 0: MOSI set while SCK low, MISO sampled just before SCK rises.
    task automatic spi_xfer(input int nbits, input bit end_frame);
        @(negedge clk_peri);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk_peri);
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = m_out[b/8][7 - (b%8)];
            repeat (4) @(negedge clk_peri);
            if (b == 0) check("miso_oe_active", int'(spi_miso_oe), 1);
            m_in[b/8][7 - (b%8)] = spi_miso;
            spi_sck = 1'b1;
            repeat (4) @(negedge clk_peri);
            spi_sck = 1'b0;
        end
        if (end_frame) begin
            repeat (4) @(negedge clk_peri);
            spi_cs_n = 1'b1;
            repeat (6) @(negedge clk_peri);
        end
        $display("spi frame bits=%0d", nbits);
    endtask

    typedef struct {
        bit         wr;
        logic [9:0] adr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        bit         exp_irq;
    } vec_t;
    vec_t vecs[18];

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         m_ovf, m_und;

    initial begin
        logic [7:0] d;
        logic [7:0] exp_in [8];
        logic [7:0] st, ctrl;
        int n, k;

        vecs[0]  = '{0, 10'h001, 8'h00, 8'h04, 1'b0};
        vecs[1]  = '{0, 10'h002, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{0, 10'h003, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{0, 10'h000, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1, 10'h002, 8'h07, 8'h00, 1'b1};
        vecs[5]  = '{0, 10'h002, 8'h00, 8'h07, 1'b1};
        vecs[6]  = '{1, 10'h000, 8'h11, 8'h00, 1'b1};
        vecs[7]  = '{1, 10'h000, 8'h22, 8'h00, 1'b1};
        vecs[8]  = '{0, 10'h001, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{1, 10'h000, 8'h33, 8'h00, 1'b1};
        vecs[10] = '{1, 10'h000, 8'h44, 8'h00, 1'b0};
        vecs[11] = '{0, 10'h001, 8'h00, 8'h08, 1'b0};
        vecs[12] = '{1, 10'h000, 8'h55, 8'h00, 1'b0};
        vecs[13] = '{1, 10'h002, 8'h0F, 8'h00, 1'b1};
        vecs[14] = '{0, 10'h002, 8'h00, 8'h07, 1'b1};
        vecs[15] = '{0, 10'h001, 8'h00, 8'h04, 1'b1};
        vecs[16] = '{0, 10'h040, 8'h00, 8'h00, 1'b1};
        vecs[17] = '{1, 10'h002, 8'h00, 8'h00, 1'b0};

        repeat (3) @(negedge clk_peri);
        check("reset_miso", int'(spi_miso), 1);
        check("reset_miso_oe", int'(spi_miso_oe), 0);
        check("reset_irq", int'(irq), 0);
        check("reset_di_peri", int'(di_peri), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk_peri);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].adr, vecs[i].data);
            end else begin
                bus_read(vecs[i].adr, d);
                check($sformatf("vec%0d_rd", i), int'(d), int'(vecs[i].exp_rd));
            end
            check($sformatf("vec%0d_irq", i), int'(irq), int'(vecs[i].exp_irq));
        end

        // Basic exchange
        bus_write(10'h000, 8'hA5);
        bus_write(10'h002, 8'h01);
        m_out[0] = 8'h3C;
        spi_xfer(8, 1'b1);
        check("xchg_master_rx", int'(m_in[0]), 8'hA5);
        read_check("xchg_status", 10'h001, 8'h25);
        read_check("xchg_data", 10'h000, 8'h3C);
        read_check("xchg_status_after", 10'h001, 8'h24);
        bus_write(10'h001, 8'h20);
        read_check("xchg_w1c", 10'h001, 8'h04);

        // Three bytes with TX empty
        m_out[0] = 8'h01; m_out[1] = 8'h02; m_out[2] = 8'h03;
        spi_xfer(24, 1'b1);
        for (int i = 0; i < 3; i++) check($sformatf("und_master_rx%0d", i), int'(m_in[i]), 8'hFF);
        read_check("und_status", 10'h001, 8'h25);
        bus_write(10'h001, 8'h20);
        read_check("und_cleared", 10'h001, 8'h05);
        for (int i = 0; i < 3; i++) read_check($sformatf("und_data%0d", i), 10'h000, 8'(i + 1));

        // Five bytes into a four-deep RX FIFO
        for (int i = 0; i < 5; i++) m_out[i] = 8'(8'h10 + i);
        spi_xfer(40, 1'b1);
        read_check("ovf_status", 10'h001, 8'h37);
        for (int i = 0; i < 4; i++) read_check($sformatf("ovf_data%0d", i), 10'h000, 8'(8'h10 + i));
        read_check("ovf_status_drained", 10'h001, 8'h34);
        bus_write(10'h001, 8'h70);
        read_check("ovf_cleared", 10'h001, 8'h04);

        // Frame aborted after five SCK pulses
        m_out[0] = 8'hAA;
        spi_xfer(5, 1'b1);
        check("abort_miso_oe", int'(spi_miso_oe), 0);
        read_check("abort_status", 10'h001, 8'h64);
        bus_write(10'h001, 8'h70);

        // RX interrupt
        bus_write(10'h000, 8'h01);
        bus_write(10'h000, 8'h02);
        bus_write(10'h002, 8'h03);
        check("irq_idle", int'(irq), 0);
        m_out[0] = 8'h77;
        spi_xfer(8, 1'b1);
        check("irq_rx_master", int'(m_in[0]), 8'h01);
        check("irq_raised", int'(irq), 1);
        read_check("irq_data", 10'h000, 8'h77);
        check("irq_fell", int'(irq), 0);

        // Randomized frames against the queue model
        m_ovf = 1'b0; m_und = 1'b0;
        for (int it = 0; it < 10; it++) begin
            ctrl = 8'h01 | 8'($urandom_range(0, 3) << 1);
            bus_write(10'h002, ctrl);
            k = $urandom_range(0, 4 - tx_q.size());
            for (int i = 0; i < k; i++) begin
                d = 8'($urandom);
                bus_write(10'h000, d);
                tx_q.push_back(d);
            end
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) m_out[i] = 8'($urandom);
            spi_xfer(n * 8, 1'b1);
            // A frame of n bytes loads n+1 times: the final reload is lost.
            for (int i = 0; i <= n; i++) begin
                if (tx_q.size() > 0) d = tx_q.pop_front();
                else begin d = 8'hFF; m_und = 1'b1; end
                if (i < n) exp_in[i] = d;
            end
            for (int i = 0; i < n; i++) begin
                if (rx_q.size() < 4) rx_q.push_back(m_out[i]);
                else m_ovf = 1'b1;
            end
            for (int i = 0; i < n; i++)
                check($sformatf("rnd%0d_master_rx%0d", it, i), int'(m_in[i]), int'(exp_in[i]));
            st = {2'b00, m_und, m_ovf, tx_q.size() == 4, tx_q.size() == 0,
                  rx_q.size() == 4, rx_q.size() != 0};
            read_check($sformatf("rnd%0d_status", it), 10'h001, st);
            check($sformatf("rnd%0d_irq", it), int'(irq),
                  int'((ctrl[1] & (rx_q.size() != 0)) | (ctrl[2] & (tx_q.size() != 4))
                       | (ctrl[1] & (m_ovf | m_und))));
            while (rx_q.size() > 0) read_check($sformatf("rnd%0d_data", it), 10'h000, rx_q.pop_front());
            bus_write(10'h001, 8'h70);
            m_ovf = 1'b0; m_und = 1'b0;
        end

        // Reset in the middle of a frame
        bus_write(10'h002, 8'h05);
        m_out[0] = 8'h81;
        spi_xfer(3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_miso_oe", int'(spi_miso_oe), 0);
        check("midreset_miso", int'(spi_miso), 1);
        check("midreset_irq", int'(irq), 0);
        check("midreset_di_peri", int'(di_peri), 0);
        spi_cs_n = 1'b1; spi_sck = 1'b0;
        repeat (3) @(negedge clk_peri);
        reset = 1'b1;
        repeat (2) @(negedge clk_peri);
        read_check("postreset_status", 10'h001, 8'h04);
        bus_write(10'h000, 8'h5A);
        bus_write(10'h002, 8'h01);
        m_out[0] = 8'hC3;
        spi_xfer(8, 1'b1);
        check("postreset_master_rx", int'(m_in[0]), 8'h5A);
        read_check("postreset_data", 10'h000, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spmc_spi_slave.md
# spmc_spi_slave

SPI slave (responder) peripheral for the SpartanMC peripheral bus, the counterpart of the SD-card SPI master peripheral: it lets an external SPI master (host MCU, another SpartanMC board) exchange bytes with firmware. Mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. SPI pins are oversampled in the `clk_peri` domain. Small RX/TX FIFOs decouple firmware from bus timing.

## Interface
- BASE_ADR, 10'h0, peripheral base address; divisible by 64; decoded via `pselect` on `addr_peri[9:6]`
- FIFO_DEPTH, 4, entries per RX and TX FIFO; power of two, 2..16
- IDLE_BYTE, 8'hFF, byte shifted out when TX FIFO is empty
- clk_peri  input  1  system clock; all logic in this domain
- reset  input  1  asynchronous, active-low reset
- do_peri  input  18  write data from MC; bits [7:0] used
- di_peri  output  18  read data to MC; {10'b0, reg} when selected and `!wr_peri`, else 18'b0
- addr_peri  input  10  address; [9:6] select, [1:0] register
- access_peri  input  1  peripheral access strobe
- wr_peri  input  1  write enable
- spi_sck  input  1  SPI clock from master, asynchronous
- spi_cs_n  input  1  chip select, active low, asynchronous
- spi_mosi  input  1  data from master, asynchronous
- spi_miso  output  1  data to master
- spi_miso_oe  output  1  MISO drive enable (1 while selected and enabled), for the top-level tristate
- irq  output  1  level interrupt

## Operation
- Registers (addr_peri[1:0]): 0 DATA (write: push TX FIFO; read: RX head, pop), 1 STATUS, 2 CTRL, 3 reads 0.
- STATUS: [0] rx_not_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_overflow, [5] tx_underrun, [6] frame_abort, [7] cs_active. Bits 4-6 sticky; write 1 to clear. Other bits read-only.
- CTRL (r/w, reset 0): [0] enable, [1] rx_ie, [2] tx_ie, [3] flush (write 1: both FIFOs emptied that cycle, reads back 0).
- irq = (rx_ie & rx_not_empty) | (tx_ie & !tx_full) | (|STATUS[6:4] & rx_ie).
- Write to DATA with TX full: ignored. Read of DATA with RX empty: returns 0, no pop.
- spi_sck, spi_cs_n, spi_mosi: 2-FF synchronizers, then edge detect on SCK and CS.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: spi_miso_oe=0. CS falling edge while enable=1 -> LOAD.
  - LOAD (1 cycle): shift register <= TX head (pop) or IDLE_BYTE (set tx_underrun if empty); bit_cnt<=0 -> SHIFT.
  - SHIFT: SCK rising: rx_shift <= {rx_shift[6:0], mosi}, bit_cnt++. When bit_cnt wraps 7->0: push RX byte (RX full: drop, set rx_overflow). SCK falling: if byte just completed -> reload as LOAD does; else tx_shift <<= 1. spi_miso = tx_shift[7].
  - CS rising edge in SHIFT: -> IDLE; bit_cnt != 0 sets frame_abort and discards partial RX byte; popped TX byte lost.
  - enable cleared mid-frame: -> IDLE immediately, no flags.
- Simultaneous: bus pop and SPI push same cycle on RX (and push/pop on TX) both take effect; count unchanged. Flag set and W1C same cycle: set wins.

## Timing
- Reset: FSM IDLE, FIFOs empty, CTRL 0, sticky flags 0, shift register 8'hFF, spi_miso 1, spi_miso_oe 0, irq 0, di_peri 0.
- Synchronizer + edge detect latency: 3 clk_peri cycles from pin to action.
- First MISO bit valid 4 clk_peri after CS falls; master waits ≥ 5 clk_peri before first SCK rising edge.
- SCK high and low phases each ≥ 4 clk_peri (f_sck ≤ f_clk_peri/8).
- RX byte visible in STATUS 1 cycle after the 8th synchronized rising edge.
- di_peri combinational from select/addr; pop/push at the clock edge ending the access cycle.

## Structure
- Shared package/include `spi_slave_pkg`: register offsets, STATUS/CTRL bit indices, FSM state encodings.
- One sub-module `spi_slave_fifo` (8-bit synchronous FIFO, parameter DEPTH, push/pop/flush, full/empty), instantiated for RX and TX; `pselect` reused for decode.

## Test plan
- Firmware writes 8'hA5 to DATA, enable=1; master sends 8'h3C in one frame -> master receives 8'hA5; DATA reads 8'h3C; STATUS[0] then 0 after read.
- Master sends 3 bytes with TX empty -> master receives 8'hFF x3; tx_underrun=1; write 8'h20 to STATUS clears it.
- FIFO_DEPTH=4, master sends 5 bytes, no reads -> RX holds first 4 bytes in order, rx_full=1, rx_overflow=1.
- CS raised after 5 SCK pulses -> frame_abort=1, RX FIFO unchanged, FSM IDLE, spi_miso_oe=0.
- rx_ie=1, one byte received -> irq rises ≤ 1 cycle after RX push, falls after DATA read.
- Reset asserted mid-frame -> all outputs at reset values asynchronously; after release, next full frame transfers correctly.
